// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder slice.
//   NIBBLE_W     width of one adder slice
//   nsa_state_t  control FSM encoding (IDLE -> RUN -> DONE -> IDLE)
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } nsa_state_t;

endpackage

// File: rtl/parallel_adder.sv
// 4-bit combinational ripple-carry adder.
// Ports:
//   a, b  in   NIBBLE_W  addends
//   cin   in   1         carry into bit 0
//   s     out  NIBBLE_W  sum
//   cout  out  1         carry out of the top bit
module parallel_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    always_comb begin
        logic [NIBBLE_W:0] c;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < NIBBLE_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that reuses one 4-bit adder stage, one nibble per clock,
// holding the inter-nibble carry in a register.
// Optional feature macro: SUBTRACT_EN (adds the `sub` port; sub=1 computes
// op_a - op_b as op_a + ~op_b + 1, cout=1 meaning no borrow).
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   start             request, sampled only in IDLE
//   op_a, op_b, cin   operands and carry-in, captured on accepted start
//   sub               (SUBTRACT_EN only) subtract select, captured on start
//   busy              high whenever not IDLE
//   res_valid         result available (DONE)
//   res_ready         consumer handshake
//   sum, cout         result, stable while res_valid
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NIBBLES*NIBBLE_W-1:0]   op_a,
    input  logic [NIBBLES*NIBBLE_W-1:0]   op_b,
    input  logic                          cin,
`ifdef SUBTRACT_EN
    input  logic                          sub,
`endif
    output logic                          busy,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [NIBBLES*NIBBLE_W-1:0]   sum,
    output logic                          cout
);

    localparam int W     = NIBBLES * NIBBLE_W;
    localparam int CNT_W = $clog2(NIBBLES);

    nsa_state_t          state;
    nsa_state_t          state_nxt;
    logic [W-1:0]        a_sh;
    logic [W-1:0]        b_sh;
    logic [W-1:0]        sum_sh;
    logic                carry;
    logic [CNT_W-1:0]    cnt;
    logic [NIBBLE_W-1:0] stage_s;
    logic                stage_c;
    logic                last_nib;
    logic [W-1:0]        b_in;
    logic                c_in;

    parallel_adder u_stage (
        .a    (a_sh[NIBBLE_W-1:0]),
        .b    (b_sh[NIBBLE_W-1:0]),
        .cin  (carry),
        .s    (stage_s),
        .cout (stage_c)
    );

    assign last_nib = (cnt == CNT_W'(NIBBLES - 1));

    // Subtraction folds into the add path: invert B and force the carry-in.
`ifdef SUBTRACT_EN
    assign b_in = sub ? ~op_b : op_b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = op_b;
    assign c_in = cin;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)     state_nxt = S_RUN;
            S_RUN:   if (last_nib)  state_nxt = S_DONE;
            S_DONE:  if (res_ready) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= op_a;
                        b_sh  <= b_in;
                        carry <= c_in;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    // Each nibble result enters at the top; after NIBBLES
                    // shifts nibble 0 has reached the bottom.
                    sum_sh <= {stage_s, sum_sh[W-1:NIBBLE_W]};
                    a_sh   <= a_sh >> NIBBLE_W;
                    b_sh   <= b_sh >> NIBBLE_W;
                    carry  <= stage_c;
                    if (!last_nib) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_DONE);
    assign sum       = sum_sh;
    assign cout      = carry;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int NIB = 4;
    localparam int W   = NIB * 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SUBTRACT_EN
    logic         sub_r;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef SUBTRACT_EN
        .sub       (sub_r),
`endif
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation with res_ready=1. lat = number of edges after the
    // start edge until res_valid is seen (-1 if it never appears).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, output logic [W-1:0] rsum, output logic rc,
                         output int lat);
        @(negedge clk);
        op_a = a; op_b = b; cin = c; start = 1'b1; res_ready = 1'b1;
`ifdef SUBTRACT_EN
        sub_r = s;
`else
        if (s) $display("note: subtract requested in add-only build");
`endif
        @(posedge clk); #1;
        start = 1'b0;
        op_a = ~a; op_b = ~b; cin = ~c;   // post-capture changes must not matter
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                lat = k;
                break;
            end
        end
        rsum = sum;
        rc   = cout;
        @(posedge clk); #1;               // result accepted on this edge
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rs;
        logic         rc;
        int           lat;
        int           nres;
        int           cyc;
        int           last_rise;
        logic         prev_v;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[3] = '{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[6] = '{16'h0999, 16'h0001, 1'b0, 16'h099A, 1'b0};

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; res_ready = 1'b0;
`ifdef SUBTRACT_EN
        sub_r = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset busy",      busy,      0);
        check("reset res_valid", res_valid, 0);
        check("reset sum",       sum,       0);
        check("reset cout",      cout,      0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven additions. res_valid is visible after edge NIB and
        // the result is taken on edge NIB+1.
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, rs, rc, lat);
            check($sformatf("vec%0d sum", i),  rs,   vecs[i].s);
            check($sformatf("vec%0d cout", i), rc,   vecs[i].co);
            check($sformatf("vec%0d lat", i),  lat,  NIB);
            check($sformatf("vec%0d idle", i), busy, 0);
        end

        // Stall in DONE while start pulses with new operands.
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; start = 1'b1; res_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (res_valid) begin lat = k; break; end
        end
        check("stall lat", lat, NIB);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; op_a = 16'h7000 + 16'(i); op_b = 16'h0123; cin = 1'b1;
            @(posedge clk); #1;
            check("stall sum",   sum,       16'h3333);
            check("stall cout",  cout,      0);
            check("stall valid", res_valid, 1);
            check("stall busy",  busy,      1);
        end
        @(negedge clk);
        res_ready = 1'b1;                  // accept with start still high
        @(posedge clk); #1;
        start = 1'b0;
        check("stall accepted", busy, 0);
        nres = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (res_valid || busy) nres++;
        end
        check("stall start dropped", nres, 0);

        // Reset in the middle of RUN.
        @(negedge clk);
        op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b0; start = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;                // start edge
        start = 1'b0;
        @(posedge clk);                    // RUN edge 1
        @(posedge clk); #1;                // RUN edge 2
        rst = 1'b1;
        #1;
        check("midrst busy",  busy,      0);
        check("midrst valid", res_valid, 0);
        check("midrst sum",   sum,       0);
        check("midrst cout",  cout,      0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("postrst busy", busy, 0);
        do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, rs, rc, lat);
        check("postrst sum",  rs,  16'h1010);
        check("postrst cout", rc,  0);
        check("postrst lat",  lat, NIB);

        // Back-to-back with start held high.
        @(negedge clk);
        op_a = 16'h0102; op_b = 16'h0304; cin = 1'b0; start = 1'b1; res_ready = 1'b1;
        nres = 0; cyc = 0; last_rise = -1; prev_v = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (res_valid && !prev_v) begin
                check("b2b sum", sum, 16'h0406);
                if (last_rise >= 0) check("b2b spacing", cyc - last_rise, NIB + 2);
                last_rise = cyc;
                nres++;
            end
            prev_v = res_valid;
        end
        start = 1'b0;
        check("b2b count", (nres >= 5) ? 1 : 0, 1);
        for (int k = 0; k < 20 && busy; k++) begin
            @(posedge clk); #1;
        end
        check("b2b drained", busy, 0);

`ifdef SUBTRACT_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rc, lat);
        check("sub 5-7 sum",  rs, 16'hFFFE);
        check("sub 5-7 cout", rc, 0);
        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, rs, rc, lat);
        check("sub 7-5 sum",  rs, 16'h0002);
        check("sub 7-5 cout", rc, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
